// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing and colour helpers for the VGA
// timing generator and its sync counter.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_GRAD  = 2'd3
    } vgaMode_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;
    localparam int DEF_RW       = 3;
    localparam int DEF_GW       = 3;
    localparam int DEF_BW       = 2;
    localparam int DEF_CHK_LOG2 = 5;

    // Channels arrive right-aligned in 8 bits; result is {R,G,B} right-aligned.
    function automatic logic [23:0] packRgb(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b, input int gw, input int bw);
        return (24'(r) << (gw + bw)) | (24'(g) << bw) | 24'(b);
    endfunction

    function automatic logic [7:0] chanFull(input logic on, input int w);
        return on ? (8'hFF >> (8 - w)) : 8'h00;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters with registered sync, active-video,
// coordinate and frame-start outputs; reusable by framebuffer readers.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HCW     = $clog2(H_TOTAL),
    localparam int VCW     = $clog2(V_TOTAL),
    localparam int XW      = $clog2(H_ACTIVE),
    localparam int YW      = $clog2(V_ACTIVE)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    output logic [HCW-1:0] o_hcnt,
    output logic [VCW-1:0] o_vcnt,
    output logic           o_active,
    output logic           o_frameFirst,
    output logic           o_lineLast,
    output logic           o_frameLast,
    output logic           o_hs,
    output logic           o_vs,
    output logic           o_de,
    output logic [XW-1:0]  o_x,
    output logic [YW-1:0]  o_y,
    output logic           o_frame_start
);

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_badTiming
        $error("vga_sync_counter: porch and sync widths must be non-zero");
    end

    localparam logic [HCW-1:0] H_LAST    = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT     = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_SYNC_B  = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] H_SYNC_E  = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0] V_LAST    = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT     = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_SYNC_B  = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] V_SYNC_E  = VCW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCW-1:0] r_hCnt;
    logic [VCW-1:0] r_vCnt;
    logic           w_lineLast;
    logic           w_frameLast;
    logic           w_active;
    logic           w_hsOn;
    logic           w_vsOn;

    assign w_lineLast  = (r_hCnt == H_LAST);
    assign w_frameLast = w_lineLast && (r_vCnt == V_LAST);
    assign w_active    = (r_hCnt < H_ACT) && (r_vCnt < V_ACT);
    assign w_hsOn      = (r_hCnt >= H_SYNC_B) && (r_hCnt < H_SYNC_E);
    assign w_vsOn      = (r_vCnt >= V_SYNC_B) && (r_vCnt < V_SYNC_E);

    assign o_hcnt       = r_hCnt;
    assign o_vcnt       = r_vCnt;
    assign o_active     = w_active;
    assign o_frameFirst = (r_hCnt == '0) && (r_vCnt == '0);
    assign o_lineLast   = w_lineLast;
    assign o_frameLast  = w_frameLast;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
        end else if (w_lineLast) begin
            r_hCnt <= '0;
            r_vCnt <= (r_vCnt == V_LAST) ? '0 : r_vCnt + VCW'(1);
        end else begin
            r_hCnt <= r_hCnt + HCW'(1);
        end
    end

    // Outputs lag the counters by one clock so they line up with registered colour.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hs          <= ~HS_POL;
            o_vs          <= ~VS_POL;
            o_de          <= 1'b0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
        end else begin
            o_hs          <= w_hsOn ? HS_POL : ~HS_POL;
            o_vs          <= w_vsOn ? VS_POL : ~VS_POL;
            o_de          <= w_active;
            o_x           <= w_active ? r_hCnt[XW-1:0] : '0;
            o_y           <= w_active ? r_vCnt[YW-1:0] : '0;
            o_frame_start <= o_frameFirst;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator driving RGB from one of four built-in
// test patterns, with pixel coordinates and frame strobes for overlays.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int RW       = DEF_RW,
    parameter int GW       = DEF_GW,
    parameter int BW       = DEF_BW,
    parameter int CHK_LOG2 = DEF_CHK_LOG2,
    localparam int CW      = RW + GW + BW,
    localparam int XW      = $clog2(H_ACTIVE),
    localparam int YW      = $clog2(V_ACTIVE)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1:0]    i_mode,
    input  logic [CW-1:0] i_solid_rgb,
    output logic          o_hs,
    output logic          o_vs,
    output logic [RW-1:0] o_r,
    output logic [GW-1:0] o_g,
    output logic [BW-1:0] o_b,
    output logic          o_de,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_frame_start,
    output logic [7:0]    o_frame_cnt
);

    if (RW < 1 || RW > 8 || GW < 1 || GW > 8 || BW < 1 || BW > 8) begin : g_badWidth
        $error("vga_timing_gen: colour channel widths must be 1..8");
    end
    if (H_ACTIVE < 8) begin : g_badBars
        $error("vga_timing_gen: H_ACTIVE must allow eight bars");
    end

    localparam int HCW   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VCW   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [HCW-1:0] H_ACT    = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] BAR_LAST = HCW'(BAR_W - 1);

    logic [HCW-1:0] w_hCnt;
    logic [VCW-1:0] w_vCnt;
    logic           w_active;
    logic           w_frameFirst;
    logic           w_lineLast;
    logic           w_frameLast;
    logic [HCW-1:0] r_barPix;
    logic [2:0]     r_barIdx;
    vgaMode_t       r_mode;
    vgaMode_t       w_mode;
    logic [7:0]     r_frameCnt;
    logic [2:0]     w_barCol;
    logic [7:0]     w_grad;
    logic [7:0]     w_v8;
    logic           w_chk;
    logic [7:0]     w_r8;
    logic [7:0]     w_g8;
    logic [7:0]     w_b8;
    logic [CW-1:0]  w_rgb;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) u_sync (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_hcnt        (w_hCnt),
        .o_vcnt        (w_vCnt),
        .o_active      (w_active),
        .o_frameFirst  (w_frameFirst),
        .o_lineLast    (w_lineLast),
        .o_frameLast   (w_frameLast),
        .o_hs          (o_hs),
        .o_vs          (o_vs),
        .o_de          (o_de),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_frame_start (o_frame_start)
    );

    // Bar index tracks hcnt with a pixel-within-bar counter; it saturates so remainder pixels stay black.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_barPix <= '0;
            r_barIdx <= '0;
        end else if (w_lineLast) begin
            r_barPix <= '0;
            r_barIdx <= '0;
        end else if (w_hCnt < H_ACT) begin
            if (r_barPix == BAR_LAST) begin
                r_barPix <= '0;
                if (r_barIdx != 3'd7) begin
                    r_barIdx <= r_barIdx + 3'd1;
                end
            end else begin
                r_barPix <= r_barPix + HCW'(1);
            end
        end
    end

    // Mode is taken only at the first pixel so a change never tears a frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode     <= MODE_SOLID;
            r_frameCnt <= '0;
        end else begin
            if (w_frameFirst) begin
                r_mode <= vgaMode_t'(i_mode);
            end
            if (w_frameLast) begin
                r_frameCnt <= r_frameCnt + 8'd1;
            end
        end
    end

    assign w_mode   = w_frameFirst ? vgaMode_t'(i_mode) : r_mode;
    assign w_barCol = 3'd7 - r_barIdx;
    assign w_grad   = 8'(w_hCnt) + r_frameCnt;
    assign w_v8     = 8'(w_vCnt);
    assign w_chk    = 1'(w_hCnt >> CHK_LOG2) ^ 1'(w_vCnt >> CHK_LOG2);

    always_comb begin
        w_r8 = 8'h00;
        w_g8 = 8'h00;
        w_b8 = 8'h00;
        if (w_active) begin
            case (w_mode)
                MODE_SOLID: begin
                    w_r8 = 8'(i_solid_rgb[CW-1 -: RW]);
                    w_g8 = 8'(i_solid_rgb[GW+BW-1 -: GW]);
                    w_b8 = 8'(i_solid_rgb[BW-1:0]);
                end
                MODE_BARS: begin
                    w_r8 = chanFull(w_barCol[1], RW);
                    w_g8 = chanFull(w_barCol[2], GW);
                    w_b8 = chanFull(w_barCol[0], BW);
                end
                MODE_CHECK: begin
                    w_r8 = chanFull(w_chk, RW);
                    w_g8 = chanFull(w_chk, GW);
                    w_b8 = chanFull(w_chk, BW);
                end
                MODE_GRAD: begin
                    w_r8 = w_grad >> (8 - RW);
                    w_g8 = w_v8 >> (8 - GW);
                    w_b8 = r_frameCnt >> (8 - BW);
                end
                default: ;
            endcase
        end
    end

    assign w_rgb = CW'(packRgb(w_r8, w_g8, w_b8, GW, BW));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_r         <= '0;
            o_g         <= '0;
            o_b         <= '0;
            o_frame_cnt <= '0;
        end else begin
            o_r         <= w_rgb[GW+BW +: RW];
            o_g         <= w_rgb[BW +: GW];
            o_b         <= w_rgb[0 +: BW];
            o_frame_cnt <= r_frameCnt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench for vga_timing_gen on a small raster: a
// pixel-index reference model predicts every output cycle.
module tb_vga_timing_gen;

    localparam int HA  = 20;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 1;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VSW = 1;
    localparam int VBP = 1;
    localparam bit HSP = 1'b1;
    localparam bit VSP = 1'b0;
    localparam int RW  = 3;
    localparam int GW  = 3;
    localparam int BW  = 2;
    localparam int CHK = 2;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int XW  = $clog2(HA);
    localparam int YW  = $clog2(VA);

    typedef struct {
        int hs, vs, de, fs, r, g, b, x, y, fc;
        bit chkXY;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [7:0]    solid_rgb = 8'h00;
    logic          hs, vs, de, fs;
    logic [RW-1:0] r;
    logic [GW-1:0] g;
    logic [BW-1:0] b;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    fcnt;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .RW(RW), .GW(GW), .BW(BW), .CHK_LOG2(CHK)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_solid_rgb(solid_rgb),
        .o_hs(hs), .o_vs(vs), .o_r(r), .o_g(g), .o_b(b), .o_de(de),
        .o_x(x), .o_y(y), .o_frame_start(fs), .o_frame_cnt(fcnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t resetExp();
        exp_t e;
        e = '{hs: int'(!HSP), vs: int'(!VSP), de: 0, fs: 0, r: 0, g: 0, b: 0,
              x: 0, y: 0, fc: 0, chkXY: 1'b1};
        return e;
    endfunction

    // Output expected for pixel index n since reset, from the raster rules.
    function automatic exp_t predict(int n, int lm, int s);
        exp_t e;
        int h, v, fc, i, c, on, gg;
        int fr, fg, fb;
        h  = n % HT;
        v  = (n / HT) % VT;
        fc = (n / FRAME) % 256;
        fr = (1 << RW) - 1;
        fg = (1 << GW) - 1;
        fb = (1 << BW) - 1;
        e = resetExp();
        e.de = (h < HA && v < VA) ? 1 : 0;
        e.hs = (h >= HA + HFP && h < HA + HFP + HSW) ? int'(HSP) : int'(!HSP);
        e.vs = (v >= VA + VFP && v < VA + VFP + VSW) ? int'(VSP) : int'(!VSP);
        e.fs = (h == 0 && v == 0) ? 1 : 0;
        e.fc = fc;
        e.x = h;
        e.y = v;
        e.chkXY = (e.de != 0);
        if (e.de != 0) begin
            case (lm)
                0: begin
                    e.r = (s >> (GW + BW)) & fr;
                    e.g = (s >> BW) & fg;
                    e.b = s & fb;
                end
                1: begin
                    i = h / (HA / 8);
                    if (i > 7) i = 7;
                    c = 7 - i;
                    e.r = ((c & 2) != 0) ? fr : 0;
                    e.g = ((c & 4) != 0) ? fg : 0;
                    e.b = ((c & 1) != 0) ? fb : 0;
                end
                2: begin
                    on = ((h >> CHK) ^ (v >> CHK)) & 1;
                    e.r = on * fr;
                    e.g = on * fg;
                    e.b = on * fb;
                end
                default: begin
                    gg = (h + fc) % 256;
                    e.r = gg >> (8 - RW);
                    e.g = (v % 256) >> (8 - GW);
                    e.b = fc >> (8 - BW);
                end
            endcase
        end
        return e;
    endfunction

    // Reference model: one expectation per clock, flushed by asynchronous reset.
    initial begin
        int mN, mMode;
        mN = 0;
        mMode = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mN = 0;
                mMode = 0;
                expQ.delete();
                expQ.push_back(resetExp());
            end else begin
                if ((mN % HT) == 0 && ((mN / HT) % VT) == 0) mMode = int'(mode);
                expQ.push_back(predict(mN, mMode, int'(solid_rgb)));
                mN++;
            end
        end
    end

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            compareVal("queue_depth", 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            compareVal("hs", 32'(hs), 32'(e.hs));
            compareVal("vs", 32'(vs), 32'(e.vs));
            compareVal("de", 32'(de), 32'(e.de));
            compareVal("frame_start", 32'(fs), 32'(e.fs));
            compareVal("frame_cnt", 32'(fcnt), 32'(e.fc));
            compareVal("red", 32'(r), 32'(e.r));
            compareVal("green", 32'(g), 32'(e.g));
            compareVal("blue", 32'(b), 32'(e.b));
            if (e.chkXY) begin
                compareVal("x", 32'(x), 32'(e.x));
                compareVal("y", 32'(y), 32'(e.y));
            end
            if (expQ.size() != 0) begin
                compareVal("queue_backlog", 32'(expQ.size()), 32'd0);
                expQ.delete();
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput();
        end
    end

    task automatic applyStimulus(input logic rstVal, input logic [1:0] m, input logic [7:0] s);
        @(posedge clk);
        #1;
        rst_n = rstVal;
        mode = m;
        solid_rgb = s;
    endtask

    initial begin
        logic [1:0] curMode;
        int rstLen;
        curMode = 2'd0;
        repeat (3) applyStimulus(1'b0, 2'd0, 8'h00);
        // Phase 1: random mode changes, random solid colour and mid-frame resets.
        for (int c = 0; c < 30 * FRAME; c++) begin
            if (c == 1000 || $urandom_range(0, 399) == 0) begin
                rstLen = (c == 1000) ? 3 : int'($urandom_range(1, 4));
                for (int k = 0; k < rstLen; k++) applyStimulus(1'b0, curMode, 8'($urandom));
            end
            if ($urandom_range(0, 149) == 0) curMode = 2'($urandom_range(0, 3));
            applyStimulus(1'b1, curMode, 8'($urandom));
        end
        // Phase 2: long uninterrupted run so frame_cnt wraps past 255.
        for (int c = 0; c < 262 * FRAME; c++) begin
            if ($urandom_range(0, 149) == 0) curMode = 2'($urandom_range(0, 3));
            applyStimulus(1'b1, curMode, 8'($urandom));
        end
        @(negedge clk);
        #1;
        compareVal("queue_drain", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA output block.
- Generates HS/VS sync and active-video timing for any resolution and sync polarity set by parameters.
- Drives R/G/B from one of four selectable built-in test patterns.
- Sits directly behind the DCM-generated pixel clock and drives the board's resistor-DAC pins. Also exports pixel coordinates and frame strobes so later overlay or framebuffer blocks can align to it.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, HS asserted level (0 = active-low)
- VS_POL, 0, VS asserted level (0 = active-low)
- RW, 3, red width
- GW, 3, green width
- BW, 2, blue width
- CHK_LOG2, 5, checkerboard square size = 2^CHK_LOG2 pixels

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 scrolling gradient
- solid_rgb  in  RW+GW+BW  colour for mode 0, packed {R,G,B}
- HS  out  1  horizontal sync
- VS  out  1  vertical sync
- R  out  RW  red
- G  out  GW  green
- B  out  BW  blue
- de  out  1  active-video flag
- x  out  clog2(H_ACTIVE)  pixel column; valid when de=1
- y  out  clog2(V_ACTIVE)  pixel row; valid when de=1
- frame_start  out  1  one-cycle pulse with first pixel (x=0, y=0)
- frame_cnt  out  8  frame counter, wraps 255->0

Behaviour:
- Reset:
  - Fixed fact: one clock domain (clk); reset is asynchronous and active-low (rst_n).
  - Asserting rst_n=0 clears hcnt, vcnt, frame_cnt, the bar counters and the latched mode (to 0) immediately.
  - While in reset: HS=~HS_POL, VS=~VS_POL, R=G=B=0, de=0, x=y=0, frame_start=0, frame_cnt=0.
  - Reset mid-frame aborts the frame. Counting restarts at (0,0) on the first clk edge after release.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
  - hcnt runs 0..H_TOTAL-1 and wraps.
  - vcnt increments when hcnt wraps, runs 0..V_TOTAL-1 and wraps.
  - Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
  - HS asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - VS asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). VS edges coincide with hcnt=0.
- Latency and alignment:
  - All outputs are registered with 1-cycle latency from the counter state.
  - HS, VS, de, x, y, RGB and frame_start are mutually aligned, with no skew between sync and colour.
- Blanking: R=G=B=0 whenever de=0, regardless of mode.
- Mode latch:
  - mode is sampled only when hcnt=0 and vcnt=0, so a pattern change never tears mid-frame.
  - frame_cnt increments at the same point; the first frame after reset shows frame_cnt=0.
- Patterns (colour channels "full" = all ones, "zero" = all zeros):
  - Mode 0: {R,G,B} = solid_rgb, sampled every pixel (not latched).
  - Mode 1, eight vertical bars:
    - BAR_W = H_ACTIVE/8, integer.
    - Bar index i comes from a per-line pixel-within-bar counter and index counter, not a divider. The index saturates at 7, so any remainder pixels are black.
    - c = 7-i; R full if c[1], G full if c[2], B full if c[0].
    - Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Mode 2, checkerboard: all channels full if x[CHK_LOG2]^y[CHK_LOG2], else zero.
  - Mode 3, gradient:
    - g = x + frame_cnt, 8-bit wrap.
    - R = g[7 -: RW]; G = y[7 -: GW] (use y[7:0] truncated); B = frame_cnt[7 -: BW].
- Widths: parameters with RW, GW or BW of 8 or less are required. Elaboration fails if any porch or sync parameter is zero.

Decomposition:
- Shared package vga_pkg:
  - Mode enum: MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_GRAD.
  - 640x480@60 default timing constants.
  - Colour-pack helper function.
- One natural sub-module: vga_sync_counter. It holds hcnt/vcnt, sync/de generation and the frame strobe, and is reusable by future framebuffer readers.
- Pattern muxing stays in vga_timing_gen.

Test Plan:
- Default params, mode=0, solid_rgb=8'hFF, run 2 frames -> HS period 800 clk, low for 96; VS period 420000 clk, low for 2 lines (1600 clk); de high 640 clk per line on 480 lines; R=7, G=7, B=3 only when de=1.
- HS_POL=1, VS_POL=1, H_ACTIVE=16, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> HS high for hcnt 18..19, line period 22; VS high on vcnt 5; frame_start once every 154 clk.
- mode=1, defaults -> at x=0 RGB={7,7,3}; x=80 {7,7,0}; x=400 {7,0,0}; x=560..639 {0,0,0}; x=79→80 boundary exact.
- mode=2, CHK_LOG2=5 -> (x=0,y=0) black; (x=32,y=0) white; (x=32,y=32) black.
- Change mode 0→3 mid-frame at y=100 -> pattern unchanged until next frame_start, then gradient; at frame_cnt=5, x=0 gives R=0, and x=251 gives R=0 (wrap).
- Assert rst_n=0 at y=200, x=300 for 3 clk -> HS/VS go inactive immediately and RGB=0; after release, frame_start fires exactly 1 clk after first edge, frame_cnt=0.
